// File: rtl/font_rom_arbiter_if.sv
// Requester / font ROM bundle for font_rom_arbiter.
// master = requesters plus ROM, slave = arbiter.
interface font_rom_arbiter_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 8
);
    logic [2:0]        req;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [ADDR_W-1:0] addr2;
    logic [2:0]        gnt;
    logic [ADDR_W-1:0] rom_addr;
    logic              rom_en;
    logic [DATA_W-1:0] rom_data;
    logic [DATA_W-1:0] rdata;
    logic [2:0]        rvalid;

    modport master (
        output req,
        output addr0,
        output addr1,
        output addr2,
        output rom_data,
        input  gnt,
        input  rom_addr,
        input  rom_en,
        input  rdata,
        input  rvalid
    );

    modport slave (
        input  req,
        input  addr0,
        input  addr1,
        input  addr2,
        input  rom_data,
        output gnt,
        output rom_addr,
        output rom_en,
        output rdata,
        output rvalid
    );
endinterface

// File: rtl/font_rom_arbiter.sv
// Shares one synchronous font ROM among hour/date/timer overlays.
// Round-robin by default; FONT_ARB_FIXED_PRIO_EN selects fixed priority.
module font_rom_arbiter #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 8
) (
    input logic              clk,
    input logic              reset,
    font_rom_arbiter_if.slave bus
);

    logic [2:0]        w_gnt;
    logic [ADDR_W-1:0] w_rom_addr;
    logic [2:0]        r_tag1;
    logic [2:0]        r_rvalid;
    logic [DATA_W-1:0] r_rdata;

`ifdef FONT_ARB_FIXED_PRIO_EN

    always_comb begin
        w_gnt = '0;
        if (bus.req[0])
            w_gnt = 3'b001;
        else if (bus.req[1])
            w_gnt = 3'b010;
        else if (bus.req[2])
            w_gnt = 3'b100;
    end

`else

    logic [1:0] r_last;
    logic [1:0] w_last_nxt;

    // Search starts after the last winner; a stray 3 behaves as 2.
    always_comb begin
        w_gnt = '0;
        case (r_last)
            2'd0: begin
                if (bus.req[1])
                    w_gnt = 3'b010;
                else if (bus.req[2])
                    w_gnt = 3'b100;
                else if (bus.req[0])
                    w_gnt = 3'b001;
            end
            2'd1: begin
                if (bus.req[2])
                    w_gnt = 3'b100;
                else if (bus.req[0])
                    w_gnt = 3'b001;
                else if (bus.req[1])
                    w_gnt = 3'b010;
            end
            default: begin
                if (bus.req[0])
                    w_gnt = 3'b001;
                else if (bus.req[1])
                    w_gnt = 3'b010;
                else if (bus.req[2])
                    w_gnt = 3'b100;
            end
        endcase
    end

    always_comb begin
        w_last_nxt = r_last;
        unique case (1'b1)
            w_gnt[0]: w_last_nxt = 2'd0;
            w_gnt[1]: w_last_nxt = 2'd1;
            w_gnt[2]: w_last_nxt = 2'd2;
            default:  w_last_nxt = r_last;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_last <= 2'd2;
        else
            r_last <= w_last_nxt;
    end

`endif

    always_comb begin
        w_rom_addr = '0;
        unique case (1'b1)
            w_gnt[0]: w_rom_addr = bus.addr0;
            w_gnt[1]: w_rom_addr = bus.addr1;
            w_gnt[2]: w_rom_addr = bus.addr2;
            default:  w_rom_addr = '0;
        endcase
    end

    // Tag travels alongside the ROM access; rdata holds between responses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tag1   <= '0;
            r_rvalid <= '0;
            r_rdata  <= '0;
        end else begin
            r_tag1   <= w_gnt;
            r_rvalid <= r_tag1;
            if (|r_tag1)
                r_rdata <= bus.rom_data;
        end
    end

    assign bus.gnt      = w_gnt;
    assign bus.rom_en   = |w_gnt;
    assign bus.rom_addr = w_rom_addr;
    assign bus.rdata    = r_rdata;
    assign bus.rvalid   = r_rvalid;

endmodule

// File: tb/tb_font_rom_arbiter.sv
// Scoreboard bench for font_rom_arbiter with a behavioural font ROM.
// Define FONT_ARB_FIXED_PRIO_EN to check the fixed-priority build.
module tb_font_rom_arbiter;
    localparam int AW = 11;
    localparam int DW = 8;

    typedef struct {
        int          due;
        logic [2:0]  tag;
        logic [DW-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    font_rom_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    font_rom_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [DW-1:0] mem [0:2047];

    always_ff @(posedge clk)
        if (bus.rom_en)
            bus.rom_data <= mem[bus.rom_addr];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int m_last = 2;
    exp_t q[$];
    logic [DW-1:0] exp_rdata = '0;
    logic [2:0] last_g = '0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [2:0] model_gnt(input logic [2:0] r,
                                             input int last);
        int l;
        int i;
`ifdef FONT_ARB_FIXED_PRIO_EN
        l = last;
        for (int k = 0; k < 3; k++)
            if (r[k]) return 3'b001 << k;
`else
        l = (last > 2) ? 2 : last;
        for (int k = 1; k <= 3; k++) begin
            i = (l + k) % 3;
            if (r[i]) return 3'b001 << i;
        end
`endif
        return 3'b000;
    endfunction

    function automatic logic [AW-1:0] addr_of(input logic [2:0] g);
        case (g)
            3'b001:  return bus.addr0;
            3'b010:  return bus.addr1;
            3'b100:  return bus.addr2;
            default: return '0;
        endcase
    endfunction

    task automatic set_addr(input int i, input logic [AW-1:0] a);
        case (i)
            0:       bus.addr0 = a;
            1:       bus.addr1 = a;
            default: bus.addr2 = a;
        endcase
    endtask

    function automatic int idx_of(input logic [2:0] g);
        return g[0] ? 0 : (g[1] ? 1 : 2);
    endfunction

    task automatic step();
        logic [2:0] eg;
        logic [2:0] ev;
        logic [AW-1:0] ea;
        exp_t e;
        @(negedge clk);
        eg = model_gnt(bus.req, m_last);
        ea = addr_of(eg);
        chk("gnt", 32'(bus.gnt), 32'(eg));
        chk("rom_en", 32'(bus.rom_en), 32'(|eg));
        chk("rom_addr", 32'(bus.rom_addr), 32'(ea));
        ev = 3'b000;
        if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            ev = e.tag;
            exp_rdata = e.data;
        end
        chk("rvalid", 32'(bus.rvalid), 32'(ev));
        chk("rdata", 32'(bus.rdata), 32'(exp_rdata));
        if (eg != 3'b000 && !reset) begin
            q.push_back('{due: cyc + 2, tag: eg, data: mem[ea]});
            m_last = idx_of(eg);
        end
        last_g = eg;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic flush_state();
        q.delete();
        exp_rdata = '0;
        m_last = 2;
    endtask

    initial begin
        for (int i = 0; i < 2048; i++)
            mem[i] = 8'($urandom);
        mem[11'h130] = 8'h3C;
        reset = 1'b1;
        bus.req = 3'b000;
        bus.addr0 = '0;
        bus.addr1 = '0;
        bus.addr2 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rvalid", 32'(bus.rvalid), 32'd0);
        chk("rst_rdata", 32'(bus.rdata), 32'd0);
        chk("rst_rom_en", 32'(bus.rom_en), 32'd0);
        reset = 1'b0;
        step();

        // single hour read of the known glyph row
        bus.req = 3'b001;
        bus.addr0 = 11'h130;
        step();
        chk("first_gnt", 32'(last_g), 32'h1);
        bus.req = 3'b000;
        step();
        step();
        chk("rdata_3c", 32'(bus.rdata), 32'h3C);
        step();

        // hour only -> last = 0, then 110 serves date then timer
        flush_state();
        reset = 1'b1;
        #1;
        reset = 1'b0;
        bus.req = 3'b001;
        bus.addr0 = 11'h055;
        step();
        bus.req = 3'b110;
        bus.addr1 = 11'h2A1;
        bus.addr2 = 11'h3F7;
        step();
        chk("p110_first", 32'(last_g), 32'h2);
        bus.req = 3'b100;
        step();
        chk("p110_second", 32'(last_g), 32'h4);
        bus.req = 3'b000;
        repeat (3) step();

        // all three requesting continuously from reset
        flush_state();
        reset = 1'b1;
        #1;
        reset = 1'b0;
        bus.req = 3'b111;
        for (int i = 0; i < 3; i++)
            set_addr(i, 11'($urandom));
        for (int i = 0; i < 9; i++) begin
            step();
`ifdef FONT_ARB_FIXED_PRIO_EN
            chk("fixed_seq", 32'(last_g), 32'h1);
`else
            chk("rr_seq", 32'(last_g), 32'(3'b001 << (i % 3)));
`endif
            set_addr(idx_of(last_g), 11'($urandom));
        end
        bus.req = 3'b000;
        repeat (3) step();

        // hour back-to-back on consecutive addresses
        bus.req = 3'b001;
        for (int i = 0; i < 3; i++) begin
            bus.addr0 = 11'(i);
            step();
        end
        bus.req = 3'b000;
        repeat (3) step();

        // reset while a date read is in flight
        bus.req = 3'b001;
        bus.addr0 = 11'h011;
        step();
        bus.req = 3'b010;
        bus.addr1 = 11'h222;
        step();
        bus.req = 3'b000;
        reset = 1'b1;
        flush_state();
        #1;
        chk("midrst_rvalid", 32'(bus.rvalid), 32'd0);
        chk("midrst_rdata", 32'(bus.rdata), 32'd0);
        repeat (3) step();
        reset = 1'b0;
        step();
        bus.req = 3'b111;
        bus.addr0 = 11'h700;
        step();
        chk("post_rst_gnt", 32'(last_g), 32'h1);
        bus.req = 3'b000;
        repeat (3) step();

        // long idle: rdata holds its last value
        repeat (10) step();

        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain left=%0d", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
